alu_sequencer: RTL and testbench

Multi-cycle execute-stage controller for the 8-bit 6502 ALU. Accepts one arithmetic/logic/read-modify-write operation at a time and fetches a memory operand when needed. Drives the ALU's operand, mode and carry inputs, then commits the result to the accumulator, the N/Z/C/V flags, or back to memory. Sits between the CPU decode stage (op handshake) and the shared ALU/memory bus.

---
 rtl/alu_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Multi-cycle execute-stage controller for the 8-bit 6502 ALU;
//            fetches memory operands, drives the ALU and commits results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter logic [4:0] MODE_ADC  = 5'b00000,
    parameter logic [4:0] MODE_AND  = 5'b00001,
    parameter logic [4:0] MODE_ORA  = 5'b00010,
    parameter logic [4:0] MODE_EOR  = 5'b00011,
    parameter logic [4:0] MODE_PASS = 5'b11111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic        op_mem,
    input  logic [15:0] op_addr,
    input  logic [7:0]  op_imm,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_mode,
    output logic        alu_carry_in,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry_out,
    input  logic        alu_overflow,
    output logic [7:0]  acc,
    output logic [3:0]  flags,
    output logic        done
);

    localparam logic [3:0] c_op_adc = 4'd0;
    localparam logic [3:0] c_op_sbc = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_ora = 4'd3;
    localparam logic [3:0] c_op_eor = 4'd4;
    localparam logic [3:0] c_op_cmp = 4'd5;
    localparam logic [3:0] c_op_asl = 4'd6;
    localparam logic [3:0] c_op_rol = 4'd7;
    localparam logic [3:0] c_op_inc = 4'd8;
    localparam logic [3:0] c_op_dec = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  r_code;
    logic        r_mem;
    logic [7:0]  r_opnd;

    logic        w_accept;
    logic        w_rmw;
    logic [7:0]  w_target;
    logic        w_n;
    logic        w_z;

    assign op_ready = (state == S_IDLE);
    assign w_accept = op_valid & op_ready;
    // Shift/inc/dec with a memory operand write their result back to memory.
    assign w_rmw    = r_mem && (r_code >= c_op_asl) && (r_code <= c_op_dec);
    assign w_target = r_mem ? r_opnd : acc;
    assign w_n      = alu_out[7];
    assign w_z      = (alu_out == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (w_accept) state_nxt = op_mem ? S_READ : S_EXEC;
            S_READ:  if (mem_ack) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = w_rmw ? S_WRITE : S_IDLE;
            S_WRITE: if (mem_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_carry_in = 1'b0;
        alu_mode     = MODE_PASS;
        if (state == S_EXEC) begin
            case (r_code)
                c_op_adc: begin
                    alu_a = acc; alu_b = r_opnd; alu_carry_in = flags[1]; alu_mode = MODE_ADC;
                end
                c_op_sbc: begin
                    alu_a = acc; alu_b = ~r_opnd; alu_carry_in = flags[1]; alu_mode = MODE_ADC;
                end
                c_op_and: begin
                    alu_a = acc; alu_b = r_opnd; alu_mode = MODE_AND;
                end
                c_op_ora: begin
                    alu_a = acc; alu_b = r_opnd; alu_mode = MODE_ORA;
                end
                c_op_eor: begin
                    alu_a = acc; alu_b = r_opnd; alu_mode = MODE_EOR;
                end
                c_op_cmp: begin
                    alu_a = acc; alu_b = ~r_opnd; alu_carry_in = 1'b1; alu_mode = MODE_ADC;
                end
                c_op_asl: begin
                    alu_a = w_target; alu_b = w_target; alu_mode = MODE_ADC;
                end
                c_op_rol: begin
                    alu_a = w_target; alu_b = w_target; alu_carry_in = flags[1]; alu_mode = MODE_ADC;
                end
                c_op_inc: begin
                    alu_a = w_target; alu_b = 8'h00; alu_carry_in = 1'b1; alu_mode = MODE_ADC;
                end
                c_op_dec: begin
                    alu_a = w_target; alu_b = 8'hFF; alu_mode = MODE_ADC;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code    <= 4'd0;
            r_mem     <= 1'b0;
            r_opnd    <= 8'h00;
            acc       <= 8'h00;
            flags     <= 4'b0000;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_code   <= op_code;
                        r_mem    <= op_mem;
                        r_opnd   <= op_imm;
                        mem_addr <= op_addr;
                        mem_req  <= op_mem;
                        mem_we   <= 1'b0;
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        r_opnd  <= mem_rdata;
                        mem_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    case (r_code)
                        c_op_adc, c_op_sbc: begin
                            acc   <= alu_out;
                            flags <= {w_n, w_z, alu_carry_out, alu_overflow};
                        end
                        c_op_and, c_op_ora, c_op_eor: begin
                            acc        <= alu_out;
                            flags[3:2] <= {w_n, w_z};
                        end
                        c_op_cmp: flags[3:1] <= {w_n, w_z, alu_carry_out};
                        c_op_asl, c_op_rol: begin
                            if (!r_mem) acc <= alu_out;
                            flags[3:1] <= {w_n, w_z, alu_carry_out};
                        end
                        c_op_inc, c_op_dec: begin
                            if (!r_mem) acc <= alu_out;
                            flags[3:2] <= {w_n, w_z};
                        end
                        default: ;
                    endcase
                    if (w_rmw) begin
                        mem_wdata <= alu_out;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Directed self-checking bench for alu_sequencer with an ALU model
//            and a wait-state memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    localparam logic [4:0] MODE_ADC  = 5'b00000;
    localparam logic [4:0] MODE_AND  = 5'b00001;
    localparam logic [4:0] MODE_ORA  = 5'b00010;
    localparam logic [4:0] MODE_EOR  = 5'b00011;
    localparam logic [4:0] MODE_PASS = 5'b11111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_code = 4'd0;
    logic        op_mem = 1'b0;
    logic [15:0] op_addr = 16'h0000;
    logic [7:0]  op_imm = 8'h00;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  alu_a, alu_b;
    logic [4:0]  alu_mode;
    logic        alu_carry_in;
    logic [7:0]  alu_out;
    logic        alu_carry_out, alu_overflow;
    logic [7:0]  acc;
    logic [3:0]  flags;
    logic        done;

    int errors = 0;
    int checks = 0;

    // Results of the most recent run_op
    int         done_cyc, req_cyc, we_cyc;
    logic       ex_seen, addr_ok, ready_at_done;
    logic [7:0] ex_a, ex_b, wdata_seen;
    logic       ex_cin;
    logic [4:0] ex_mode;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_mem(op_mem), .op_addr(op_addr), .op_imm(op_imm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_carry_in(alu_carry_in), .alu_out(alu_out),
        .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
        .acc(acc), .flags(flags), .done(done)
    );

    // Reference 6502 ALU
    always_comb begin
        logic [8:0] s;
        s = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_carry_in);
        alu_out       = alu_a;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_mode)
            MODE_ADC: begin
                alu_out       = s[7:0];
                alu_carry_out = s[8];
                alu_overflow  = (alu_a[7] == alu_b[7]) && (s[7] != alu_a[7]);
            end
            MODE_AND: alu_out = alu_a & alu_b;
            MODE_ORA: alu_out = alu_a | alu_b;
            MODE_EOR: alu_out = alu_a ^ alu_b;
            default:  alu_out = alu_a;
        endcase
    end

    // Issue one op and act as memory until done; cycle 1 is the cycle after accept.
    task automatic run_op(input logic [3:0] code, input logic mem, input logic [15:0] addr,
                          input logic [7:0] imm, input logic [7:0] rdata,
                          input int rwait, input int wwait);
        int cyc, rcnt, wcnt;
        op_code = code; op_mem = mem; op_addr = addr; op_imm = imm; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        done_cyc = -1; req_cyc = 0; we_cyc = 0; ex_seen = 1'b0; addr_ok = 1'b1;
        ready_at_done = 1'b0; wdata_seen = 8'h00;
        ex_a = 8'h00; ex_b = 8'h00; ex_cin = 1'b0; ex_mode = MODE_PASS;
        cyc = 1; rcnt = 0; wcnt = 0;
        while (cyc <= 40) begin
            if (done) begin
                done_cyc = cyc;
                ready_at_done = op_ready;
                break;
            end
            if (alu_mode != MODE_PASS && !ex_seen) begin
                ex_seen = 1'b1; ex_a = alu_a; ex_b = alu_b; ex_cin = alu_carry_in; ex_mode = alu_mode;
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cyc++;
                if (mem_addr !== addr) addr_ok = 1'b0;
                if (mem_we) begin
                    we_cyc++;
                    wdata_seen = mem_wdata;
                    if (wcnt == wwait) mem_ack = 1'b1;
                    wcnt++;
                end else begin
                    mem_rdata = rdata;
                    if (rcnt == rwait) mem_ack = 1'b1;
                    rcnt++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", op_ready); end
        checks++; if ({acc, flags, done} !== 13'h0) begin errors++; $display("FAIL reset_regs: acc=%h flags=%b done=%b expected 0", acc, flags, done); end
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 26'h0) begin errors++; $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h expected 0", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if ({alu_mode, alu_a, alu_b, alu_carry_in} !== {MODE_PASS, 17'h0}) begin errors++; $display("FAIL reset_alu: mode=%b a=%h b=%h cin=%b expected PASS/0", alu_mode, alu_a, alu_b, alu_carry_in); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_adc();
        run_op(4'd0, 1'b0, 16'h0, 8'h50, 8'h00, 0, 0);
        checks++; if ({acc, flags} !== {8'h50, 4'b0000}) begin errors++; $display("FAIL adc_load: acc=%h flags=%b expected 50/0000", acc, flags); end
        run_op(4'd0, 1'b0, 16'h0, 8'h50, 8'h00, 0, 0);
        checks++; if ({ex_a, ex_b, ex_cin, ex_mode} !== {8'h50, 8'h50, 1'b0, MODE_ADC}) begin errors++; $display("FAIL adc_alu: a=%h b=%h cin=%b mode=%b expected 50/50/0/ADC", ex_a, ex_b, ex_cin, ex_mode); end
        checks++; if ({acc, flags} !== {8'hA0, 4'b1001}) begin errors++; $display("FAIL adc_result: acc=%h flags=%b expected a0/1001", acc, flags); end
        checks++; if (done_cyc !== 2 || ready_at_done !== 1'b1) begin errors++; $display("FAIL adc_timing: done_cyc=%0d ready=%b expected 2/1", done_cyc, ready_at_done); end
    endtask

    task automatic test_sbc();
        run_op(4'd5, 1'b0, 16'h0, 8'h00, 8'h00, 0, 0);
        checks++; if ({acc, flags} !== {8'hA0, 4'b1011}) begin errors++; $display("FAIL cmp_imm: acc=%h flags=%b expected a0/1011", acc, flags); end
        run_op(4'd2, 1'b0, 16'h0, 8'h00, 8'h00, 0, 0);
        checks++; if ({acc, flags} !== {8'h00, 4'b0111}) begin errors++; $display("FAIL and_zero: acc=%h flags=%b expected 00/0111", acc, flags); end
        run_op(4'd1, 1'b0, 16'h0, 8'h01, 8'h00, 0, 0);
        checks++; if ({ex_b, ex_cin} !== {8'hFE, 1'b1}) begin errors++; $display("FAIL sbc_alu: b=%h cin=%b expected fe/1", ex_b, ex_cin); end
        checks++; if ({acc, flags} !== {8'hFF, 4'b1000}) begin errors++; $display("FAIL sbc_result: acc=%h flags=%b expected ff/1000", acc, flags); end
    endtask

    task automatic test_cmp_mem();
        run_op(4'd2, 1'b0, 16'h0, 8'h40, 8'h00, 0, 0);
        checks++; if ({acc, flags} !== {8'h40, 4'b0000}) begin errors++; $display("FAIL and_40: acc=%h flags=%b expected 40/0000", acc, flags); end
        run_op(4'd5, 1'b1, 16'h0300, 8'h00, 8'h40, 3, 0);
        checks++; if (req_cyc !== 4 || we_cyc !== 0 || addr_ok !== 1'b1) begin errors++; $display("FAIL cmp_mem_bus: req=%0d we=%0d addr_ok=%b expected 4/0/1", req_cyc, we_cyc, addr_ok); end
        checks++; if ({acc, flags} !== {8'h40, 4'b0110}) begin errors++; $display("FAIL cmp_mem_result: acc=%h flags=%b expected 40/0110", acc, flags); end
        checks++; if (done_cyc !== 6) begin errors++; $display("FAIL cmp_mem_done: got %0d expected 6", done_cyc); end
    endtask

    task automatic test_inc_mem();
        run_op(4'd8, 1'b1, 16'h0200, 8'h00, 8'hFF, 0, 2);
        checks++; if ({ex_a, ex_b, ex_cin} !== {8'hFF, 8'h00, 1'b1}) begin errors++; $display("FAIL inc_alu: a=%h b=%h cin=%b expected ff/00/1", ex_a, ex_b, ex_cin); end
        checks++; if (we_cyc !== 3 || req_cyc !== 4 || wdata_seen !== 8'h00 || addr_ok !== 1'b1) begin errors++; $display("FAIL inc_bus: we=%0d req=%0d wdata=%h addr_ok=%b expected 3/4/00/1", we_cyc, req_cyc, wdata_seen, addr_ok); end
        checks++; if ({acc, flags} !== {8'h40, 4'b0110}) begin errors++; $display("FAIL inc_result: acc=%h flags=%b expected 40/0110", acc, flags); end
        checks++; if (done_cyc !== 6 || mem_req !== 1'b0) begin errors++; $display("FAIL inc_done: cyc=%0d req=%b expected 6/0", done_cyc, mem_req); end
    endtask

    task automatic test_reset_mid();
        op_code = 4'd6; op_mem = 1'b1; op_addr = 16'h0210; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; mem_rdata = 8'h81; mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        checks++; if ({mem_req, mem_we, mem_wdata} !== {2'b11, 8'h02}) begin errors++; $display("FAIL rmw_write: req=%b we=%b wdata=%h expected 1/1/02", mem_req, mem_we, mem_wdata); end
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL async_drop: req=%b we=%b expected 0/0", mem_req, mem_we); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({op_ready, acc, flags} !== {1'b1, 8'h00, 4'b0000}) begin errors++; $display("FAIL post_reset: ready=%b acc=%h flags=%b expected 1/00/0000", op_ready, acc, flags); end
        run_op(4'd0, 1'b0, 16'h0, 8'h01, 8'h00, 0, 0);
        checks++; if ({acc, flags} !== {8'h01, 4'b0000}) begin errors++; $display("FAIL adc_after_reset: acc=%h flags=%b expected 01/0000", acc, flags); end
    endtask

    task automatic test_illegal_busy();
        op_code = 4'd12; op_mem = 1'b0; op_imm = 8'h77; op_valid = 1'b1;
        @(posedge clk); #1;
        op_code = 4'd0; op_imm = 8'h05;
        checks++; if ({op_ready, alu_mode, mem_req} !== {1'b0, MODE_PASS, 1'b0}) begin errors++; $display("FAIL illegal_exec: ready=%b mode=%b req=%b expected 0/PASS/0", op_ready, alu_mode, mem_req); end
        @(posedge clk); #1;
        checks++; if ({done, op_ready, acc, flags} !== {2'b11, 8'h01, 4'b0000}) begin errors++; $display("FAIL illegal_done: done=%b ready=%b acc=%h flags=%b expected 1/1/01/0000", done, op_ready, acc, flags); end
        @(posedge clk); #1;
        op_valid = 1'b0;
        checks++; if ({done, op_ready, acc} !== {2'b00, 8'h01}) begin errors++; $display("FAIL held_exec: done=%b ready=%b acc=%h expected 0/0/01", done, op_ready, acc); end
        @(posedge clk); #1;
        checks++; if ({done, acc} !== {1'b1, 8'h06}) begin errors++; $display("FAIL held_result: done=%b acc=%h expected 1/06", done, acc); end
        @(posedge clk); #1;
    endtask

    task automatic test_accumulator_ops();
        run_op(4'd4, 1'b0, 16'h0, 8'h87, 8'h00, 0, 0);
        checks++; if ({acc, flags} !== {8'h81, 4'b1000}) begin errors++; $display("FAIL eor: acc=%h flags=%b expected 81/1000", acc, flags); end
        run_op(4'd6, 1'b0, 16'h0, 8'h00, 8'h00, 0, 0);
        checks++; if ({ex_a, ex_b, ex_cin, acc, flags} !== {8'h81, 8'h81, 1'b0, 8'h02, 4'b0010}) begin errors++; $display("FAIL asl_acc: a=%h b=%h cin=%b acc=%h flags=%b expected 81/81/0/02/0010", ex_a, ex_b, ex_cin, acc, flags); end
        run_op(4'd7, 1'b0, 16'h0, 8'h00, 8'h00, 0, 0);
        checks++; if ({ex_cin, acc, flags} !== {1'b1, 8'h05, 4'b0000}) begin errors++; $display("FAIL rol_acc: cin=%b acc=%h flags=%b expected 1/05/0000", ex_cin, acc, flags); end
        run_op(4'd3, 1'b0, 16'h0, 8'h80, 8'h00, 0, 0);
        checks++; if ({acc, flags} !== {8'h85, 4'b1000}) begin errors++; $display("FAIL ora: acc=%h flags=%b expected 85/1000", acc, flags); end
        run_op(4'd9, 1'b0, 16'h0, 8'h00, 8'h00, 0, 0);
        checks++; if ({ex_b, acc, flags} !== {8'hFF, 8'h84, 4'b1000}) begin errors++; $display("FAIL dec_acc: b=%h acc=%h flags=%b expected ff/84/1000", ex_b, acc, flags); end
    endtask

    initial begin
        test_reset();
        test_adc();
        test_sbc();
        test_cmp_mem();
        test_inc_mem();
        test_reset_mid();
        test_illegal_busy();
        test_accumulator_ops();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
